// File: rtl/median_window_ctrl.sv
// 3x3 window sequencer for a gray median filter: line buffering, window issue,
// end-of-frame drain and latency-matched output with border bypass.
module median_window_ctrl #(
  parameter int DW         = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FILTER_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vsync,
  input  logic          in_de,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [DW-1:0] win11,
  output logic [DW-1:0] win12,
  output logic [DW-1:0] win13,
  output logic [DW-1:0] win21,
  output logic [DW-1:0] win22,
  output logic [DW-1:0] win23,
  output logic [DW-1:0] win31,
  output logic [DW-1:0] win32,
  output logic [DW-1:0] win33,
  output logic          win_valid,
  input  logic [DW-1:0] median_in,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sof,
  output logic          out_eof,
  output logic          err_abort
);
  localparam int W     = IMG_WIDTH;
  localparam int H     = IMG_HEIGHT;
  localparam int DEPTH = 2 * W + 3;
  localparam int XW    = $clog2(W);
  localparam int YW    = $clog2(H);
  localparam logic [XW-1:0] XMAX = XW'(W - 1);
  localparam logic [YW-1:0] YMAX = YW'(H - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic          vld;
    logic          byp;
    logic          sof;
    logic          eof;
    logic [DW-1:0] ctr;
  } iss_t;

  state_t        state_q;
  logic          rdy_q;
  logic          err_q;
  logic [XW-1:0] ix_q;
  logic [YW-1:0] iy_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;
  logic          iss_q;
  logic          byp_q;
  logic          sof_q;
  logic          eof_q;
  logic [DW-1:0] dl_q   [DEPTH];
  logic [DW-1:0] tap_q  [9];
  iss_t          pipe_q [FILTER_LAT+1];
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          out_sof_q;
  logic          out_eof_q;

  logic acc;
  logic iss;
  logic shift;
  logic n_w;
  logic n_last;
  logic c_byp;
  logic c_sof;
  logic c_eof;

  always_comb begin
    acc    = in_de & rdy_q & ~in_vsync
           & ((state_q == FILL) | (state_q == RUN));
    iss    = ~in_vsync
           & (((state_q == RUN) & acc) | (state_q == FLUSH));
    shift  = acc | (~in_vsync & (state_q == FLUSH));
    n_w    = (iy_q == YW'(1)) & (ix_q == '0);
    n_last = (iy_q == YMAX) & (ix_q == XMAX);
    c_sof  = (cy_q == '0) & (cx_q == '0);
    c_eof  = (cy_q == YMAX) & (cx_q == XMAX);
    c_byp  = (cy_q == '0) | (cy_q == YMAX)
           | (cx_q == '0) | (cx_q == XMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
      ix_q    <= '0;
      iy_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      iss_q   <= 1'b0;
      byp_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      iss_q <= iss;
      byp_q <= c_byp;
      sof_q <= c_sof;
      eof_q <= c_eof;
      if (in_vsync) begin
        // a frame start always restarts; mid-frame it also flags the abort
        err_q   <= (state_q != IDLE);
        state_q <= FILL;
        rdy_q   <= 1'b1;
        ix_q    <= '0;
        iy_q    <= '0;
        cx_q    <= '0;
        cy_q    <= '0;
      end else begin
        if (acc) begin
          ix_q <= (ix_q == XMAX) ? '0 : ix_q + 1'b1;
          if (ix_q == XMAX)
            iy_q <= (iy_q == YMAX) ? '0 : iy_q + 1'b1;
        end
        if (iss) begin
          cx_q <= (cx_q == XMAX) ? '0 : cx_q + 1'b1;
          if (cx_q == XMAX)
            cy_q <= (cy_q == YMAX) ? '0 : cy_q + 1'b1;
        end
        unique case (state_q)
          IDLE: ;
          FILL: begin
            if (acc && n_w)
              state_q <= RUN;
          end
          RUN: begin
            if (acc && n_last) begin
              state_q <= FLUSH;
              rdy_q   <= 1'b0;
            end
          end
          FLUSH: begin
            if (c_eof) begin
              state_q <= IDLE;
              rdy_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Line buffers hold pixel data only and are deliberately not reset.
  always_ff @(posedge clk) begin
    if (shift) begin
      dl_q[0] <= acc ? in_data : '0;
      for (int i = 1; i < DEPTH; i++)
        dl_q[i] <= dl_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++)
        tap_q[i] <= '0;
      for (int k = 0; k <= FILTER_LAT; k++)
        pipe_q[k] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
    end else begin
      if (iss_q) begin
        tap_q[0] <= dl_q[2*W+2];
        tap_q[1] <= dl_q[2*W+1];
        tap_q[2] <= dl_q[2*W];
        tap_q[3] <= dl_q[W+2];
        tap_q[4] <= dl_q[W+1];
        tap_q[5] <= dl_q[W];
        tap_q[6] <= dl_q[2];
        tap_q[7] <= dl_q[1];
        tap_q[8] <= dl_q[0];
      end
      pipe_q[0] <= '{vld: iss_q, byp: byp_q, sof: sof_q,
                     eof: eof_q, ctr: dl_q[W+1]};
      for (int k = 1; k <= FILTER_LAT; k++)
        pipe_q[k] <= pipe_q[k-1];
      out_valid_q <= pipe_q[FILTER_LAT].vld;
      out_sof_q   <= pipe_q[FILTER_LAT].vld & pipe_q[FILTER_LAT].sof;
      out_eof_q   <= pipe_q[FILTER_LAT].vld & pipe_q[FILTER_LAT].eof;
      if (pipe_q[FILTER_LAT].vld)
        out_data_q <= pipe_q[FILTER_LAT].byp ? pipe_q[FILTER_LAT].ctr
                                             : median_in;
    end
  end

  assign in_ready  = rdy_q;
  assign err_abort = err_q;
  assign win11     = tap_q[0];
  assign win12     = tap_q[1];
  assign win13     = tap_q[2];
  assign win21     = tap_q[3];
  assign win22     = tap_q[4];
  assign win23     = tap_q[5];
  assign win31     = tap_q[6];
  assign win32     = tap_q[7];
  assign win33     = tap_q[8];
  assign win_valid = pipe_q[0].vld;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

endmodule
